bullet_pool_arbiter: RTL and testbench

Owns the shared pool of player bullet slots consumed by the enemy hit logic. It arbitrates fire requests from several requesters (player ship, power-up side guns) round-robin and allocates each granted shot to the lowest free slot. Every move tick it advances active bullets upward. Slots are retired on a hit pulse from the enemy controllers or when a bullet leaves the top of the screen. Its flattened slot outputs drive the enemy controllers' bullet inputs and the sprite renderer directly.

---
 rtl/game_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/bullet_pool_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_bullet_pool_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants used by the bullet pool, enemy controllers and sprite
// renderer, plus the index-width helper used to size slot/requester indices.
package game_pkg;

  localparam int COORD_W  = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Width of an index able to address n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans the requests starting at ptr and
// returns the first asserted one as a one-hot grant plus its index. When en is
// low nothing is granted.
module rr_arbiter
  import game_pkg::*;
#(
  parameter int REQ_COUNT = 2,
  localparam int PTR_W = idx_w(REQ_COUNT)
) (
  input  logic [REQ_COUNT-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  input  logic                 en,
  output logic [REQ_COUNT-1:0] grant,
  output logic [PTR_W-1:0]     winner,
  output logic                 valid
);

  int idx;

  // Rotating scan from ptr; the first asserted request wins.
  always_comb begin
    grant  = '0;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    if (en) begin
      for (int i = 0; i < REQ_COUNT; i++) begin
        idx = int'(ptr) + i;
        if (idx >= REQ_COUNT) idx = idx - REQ_COUNT;
        if (!valid && req[PTR_W'(idx)]) begin
          valid                = 1'b1;
          winner               = PTR_W'(idx);
          grant[PTR_W'(idx)]   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bullet_pool_arbiter.sv
// Shared player bullet pool: round-robin fire arbitration, lowest-free-slot
// allocation, periodic upward motion, and retirement on hit or top exit.
// Optional per-requester fire cooldown is compiled in with BULLET_COOLDOWN_EN.
module bullet_pool_arbiter
  import game_pkg::*;
#(
  parameter int BULLET_COUNT    = 8,
  parameter int REQ_COUNT       = 2,
  parameter int MOVE_PERIOD     = 416667,
  parameter int BULLET_SPEED    = 4,
  parameter int COOLDOWN_CYCLES = 3125000
) (
  input  logic                            clk25,
  input  logic                            reset,
  input  logic [REQ_COUNT-1:0]            fire_req,
  input  logic [COORD_W*REQ_COUNT-1:0]    fire_x_flat,
  input  logic [COORD_W*REQ_COUNT-1:0]    fire_y_flat,
  output logic [REQ_COUNT-1:0]            fire_grant,
  input  logic [BULLET_COUNT-1:0]         bullet_hit,
  output logic [COORD_W*BULLET_COUNT-1:0] bullet_x_flat,
  output logic [COORD_W*BULLET_COUNT-1:0] bullet_y_flat,
  output logic [BULLET_COUNT-1:0]         bullet_active_flat,
  output logic                            pool_full
);

  localparam int SLOT_W = idx_w(BULLET_COUNT);
  localparam int PTR_W  = idx_w(REQ_COUNT);
  localparam int TICK_W = $clog2(MOVE_PERIOD);
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(MOVE_PERIOD - 1);
  localparam logic [COORD_W-1:0] SPEED     = COORD_W'(BULLET_SPEED);

  logic [BULLET_COUNT-1:0] active_q, active_d;
  logic [COORD_W-1:0]      x_q [BULLET_COUNT];
  logic [COORD_W-1:0]      x_d [BULLET_COUNT];
  logic [COORD_W-1:0]      y_q [BULLET_COUNT];
  logic [COORD_W-1:0]      y_d [BULLET_COUNT];
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [TICK_W-1:0]       tick_cnt_q, tick_cnt_d;
  logic [REQ_COUNT-1:0]    grant_q, grant_d;
  logic                    pool_full_q, pool_full_d;

  logic                    tick;
  logic [BULLET_COUNT-1:0] free_mask;
  logic [SLOT_W-1:0]       target_idx;
  logic                    target_ok;
  logic [REQ_COUNT-1:0]    eligible;
  logic [REQ_COUNT-1:0]    arb_grant;
  logic [PTR_W-1:0]        arb_winner;
  logic                    arb_valid;
  logic [COORD_W-1:0]      spawn_x, spawn_y;

  // Free slots come from registered state only, so a slot retired this cycle
  // cannot be handed out until the following cycle.
  assign free_mask = ~active_q;

  // Lowest-index free slot is the allocation target.
  always_comb begin
    target_idx = '0;
    target_ok  = 1'b0;
    for (int s = 0; s < BULLET_COUNT; s++) begin
      if (!target_ok && free_mask[s]) begin
        target_ok  = 1'b1;
        target_idx = SLOT_W'(s);
      end
    end
  end

`ifdef BULLET_COOLDOWN_EN
  localparam int CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_CYCLES - 1);

  logic [CD_W-1:0] cd_q [REQ_COUNT];
  logic [CD_W-1:0] cd_d [REQ_COUNT];

  // Per-requester cooldown: reload on grant, count down to zero, eligible at zero.
  always_comb begin
    for (int r = 0; r < REQ_COUNT; r++) begin
      eligible[r] = (cd_q[r] == '0);
      cd_d[r]     = cd_q[r];
      if (arb_grant[r]) begin
        cd_d[r] = CD_LOAD;
      end else if (cd_q[r] != '0) begin
        cd_d[r] = cd_q[r] - 1'b1;
      end
    end
  end

  // Cooldown counter registers.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < REQ_COUNT; r++) cd_q[r] <= '0;
    end else begin
      for (int r = 0; r < REQ_COUNT; r++) cd_q[r] <= cd_d[r];
    end
  end
`else
  // Without cooldown every requester is always eligible.
  always_comb begin
    eligible = '1;
  end
`endif

  rr_arbiter #(
    .REQ_COUNT (REQ_COUNT)
  ) u_rr_arbiter (
    .req    (fire_req & eligible),
    .ptr    (rr_ptr_q),
    .en     (target_ok),
    .grant  (arb_grant),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  // Spawn coordinates of the winning requester.
  always_comb begin
    spawn_x = '0;
    spawn_y = '0;
    for (int r = 0; r < REQ_COUNT; r++) begin
      if (arb_grant[r]) begin
        spawn_x = fire_x_flat[r*COORD_W +: COORD_W];
        spawn_y = fire_y_flat[r*COORD_W +: COORD_W];
      end
    end
  end

  // Move-tick counter, pointer advance and grant pulse.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    rr_ptr_d   = rr_ptr_q;
    if (arb_valid) begin
      rr_ptr_d = (int'(arb_winner) == REQ_COUNT - 1) ? '0 : arb_winner + 1'b1;
    end
    grant_d = arb_grant;
  end

  // Per-slot update; a hit beats everything, a fresh spawn is not moved by a
  // coincident tick, and a bullet that would cross the top is retired rather
  // than letting y wrap.
  always_comb begin
    for (int s = 0; s < BULLET_COUNT; s++) begin
      active_d[s] = active_q[s];
      x_d[s]      = x_q[s];
      y_d[s]      = y_q[s];
      if (bullet_hit[s] && active_q[s]) begin
        active_d[s] = 1'b0;
      end else if (arb_valid && (SLOT_W'(s) == target_idx)) begin
        active_d[s] = 1'b1;
        x_d[s]      = spawn_x;
        y_d[s]      = spawn_y;
      end else if (tick && active_q[s]) begin
        if (y_q[s] < SPEED) begin
          active_d[s] = 1'b0;
        end else begin
          y_d[s] = y_q[s] - SPEED;
        end
      end
    end
    pool_full_d = &active_d;
  end

  // State registers.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      active_q    <= '0;
      rr_ptr_q    <= '0;
      tick_cnt_q  <= '0;
      grant_q     <= '0;
      pool_full_q <= 1'b0;
      for (int s = 0; s < BULLET_COUNT; s++) begin
        x_q[s] <= '0;
        y_q[s] <= '0;
      end
    end else begin
      active_q    <= active_d;
      rr_ptr_q    <= rr_ptr_d;
      tick_cnt_q  <= tick_cnt_d;
      grant_q     <= grant_d;
      pool_full_q <= pool_full_d;
      for (int s = 0; s < BULLET_COUNT; s++) begin
        x_q[s] <= x_d[s];
        y_q[s] <= y_d[s];
      end
    end
  end

  // Flatten slot state onto the output buses.
  always_comb begin
    for (int s = 0; s < BULLET_COUNT; s++) begin
      bullet_x_flat[s*COORD_W +: COORD_W] = x_q[s];
      bullet_y_flat[s*COORD_W +: COORD_W] = y_q[s];
    end
  end

  assign bullet_active_flat = active_q;
  assign fire_grant         = grant_q;
  assign pool_full          = pool_full_q;

endmodule

// File: tb/tb_bullet_pool_arbiter.sv
// Scoreboard bench for bullet_pool_arbiter. A behavioural pool model predicts
// each cycle's outputs into a queue; a monitor compares them after each edge.
module tb_bullet_pool_arbiter;

  localparam int BC  = 8;
  localparam int RC  = 2;
  localparam int MP  = 4;
  localparam int SPD = 4;
  localparam int CD  = 10;
  localparam int CW  = 10;

  logic               clk25 = 1'b0;
  logic               reset = 1'b1;
  logic [RC-1:0]      fire_req = '0;
  logic [CW*RC-1:0]   fire_x_flat = '0;
  logic [CW*RC-1:0]   fire_y_flat = '0;
  logic [RC-1:0]      fire_grant;
  logic [BC-1:0]      bullet_hit = '0;
  logic [CW*BC-1:0]   bullet_x_flat;
  logic [CW*BC-1:0]   bullet_y_flat;
  logic [BC-1:0]      bullet_active_flat;
  logic               pool_full;

  always #5 clk25 = ~clk25;

  bullet_pool_arbiter #(
    .BULLET_COUNT    (BC),
    .REQ_COUNT       (RC),
    .MOVE_PERIOD     (MP),
    .BULLET_SPEED    (SPD),
    .COOLDOWN_CYCLES (CD)
  ) dut (
    .clk25              (clk25),
    .reset              (reset),
    .fire_req           (fire_req),
    .fire_x_flat        (fire_x_flat),
    .fire_y_flat        (fire_y_flat),
    .fire_grant         (fire_grant),
    .bullet_hit         (bullet_hit),
    .bullet_x_flat      (bullet_x_flat),
    .bullet_y_flat      (bullet_y_flat),
    .bullet_active_flat (bullet_active_flat),
    .pool_full          (pool_full)
  );

  typedef struct packed {
    logic [RC-1:0]    grant;
    logic [BC-1:0]    act;
    logic [CW*BC-1:0] xf;
    logic [CW*BC-1:0] yf;
    logic             full;
  } snap_t;

  snap_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a pool of slots, a pointer, a cycle count and requesters.
  bit m_act[BC];
  int m_x[BC];
  int m_y[BC];
  int m_rr;
  int m_cnt;
  int m_cd[RC];
  bit pend[RC];
  int px[RC];
  int py[RC];
  int last_grant_cycle;
  int cyc;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < BC; s++) begin
      m_act[s] = 0; m_x[s] = 0; m_y[s] = 0;
    end
    for (int r = 0; r < RC; r++) m_cd[r] = 0;
    m_rr = 0;
    m_cnt = 0;
  endtask

  function automatic bit eligible(input int r);
`ifdef BULLET_COOLDOWN_EN
    return m_cd[r] == 0;
`else
    return 1'b1;
`endif
  endfunction

  // Drive this cycle's inputs and predict the state right after the next edge.
  task automatic drive_and_predict(input logic [BC-1:0] hit);
    bit   tick;
    int   free_s;
    int   w;
    int   r;
    snap_t e;
    for (int i = 0; i < RC; i++) begin
      fire_req[i] = pend[i];
      fire_x_flat[i*CW +: CW] = CW'(px[i]);
      fire_y_flat[i*CW +: CW] = CW'(py[i]);
    end
    bullet_hit = hit;

    tick  = (m_cnt == MP - 1);
    m_cnt = tick ? 0 : m_cnt + 1;

    free_s = -1;
    for (int s = BC - 1; s >= 0; s--) if (!m_act[s]) free_s = s;

    w = -1;
    if (free_s >= 0) begin
      for (int k = 0; k < RC; k++) begin
        r = (m_rr + k) % RC;
        if (w < 0 && pend[r] && eligible(r)) w = r;
      end
    end
    for (int i = 0; i < RC; i++) begin
      if (i == w) m_cd[i] = CD - 1;
      else if (m_cd[i] > 0) m_cd[i] = m_cd[i] - 1;
    end
    if (w >= 0) m_rr = (w + 1) % RC;

    for (int s = 0; s < BC; s++) begin
      if (hit[s] && m_act[s]) begin
        m_act[s] = 0;
      end else if (w >= 0 && s == free_s) begin
        m_act[s] = 1; m_x[s] = px[w]; m_y[s] = py[w];
      end else if (tick && m_act[s]) begin
        if (m_y[s] < SPD) m_act[s] = 0;
        else m_y[s] = m_y[s] - SPD;
      end
    end

    e.grant = '0;
    if (w >= 0) e.grant[w] = 1'b1;
    e.full = 1'b1;
    for (int s = 0; s < BC; s++) begin
      e.act[s] = m_act[s];
      e.xf[s*CW +: CW] = CW'(m_x[s]);
      e.yf[s*CW +: CW] = CW'(m_y[s]);
      if (!m_act[s]) e.full = 1'b0;
    end
    exp_q.push_back(e);

    if (w >= 0) begin
      pend[w] = 0;
      last_grant_cycle = cyc;
    end
    cyc++;
  endtask

  task automatic cycle(input logic [BC-1:0] hit);
    @(negedge clk25);
    drive_and_predict(hit);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_active"}, 128'(bullet_active_flat), 128'(0));
    chk({tag, "_grant"},  128'(fire_grant), 128'(0));
    chk({tag, "_full"},   128'(pool_full), 128'(0));
    chk({tag, "_x"},      128'(bullet_x_flat), 128'(0));
    chk({tag, "_y"},      128'(bullet_y_flat), 128'(0));
  endtask

  // Release reset on a negedge and drive the first cycle in the same slot.
  task automatic release_reset();
    @(negedge clk25);
    reset = 1'b0;
    drive_and_predict('0);
  endtask

  // Asynchronous reset off the clock edge, checked immediately.
  task automatic pulse_reset();
    @(negedge clk25);
    #2 reset = 1'b1;
    #1 check_cleared("midreset");
    model_reset();
    release_reset();
  endtask

  task automatic rand_cycle(input int hit_odds);
    logic [BC-1:0] hit;
    for (int r = 0; r < RC; r++) begin
      if (!pend[r] && $urandom_range(2) == 0) begin
        pend[r] = 1;
        px[r] = $urandom_range(639);
        py[r] = ($urandom_range(3) == 0) ? $urandom_range(12) : $urandom_range(479);
      end
    end
    hit = '0;
    for (int s = 0; s < BC; s++) if ($urandom_range(hit_odds) == 0) hit[s] = 1'b1;
    cycle(hit);
  endtask

  // Monitor: pop the prediction for every edge that has one and compare.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk25);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant",  128'(fire_grant), 128'(e.grant));
        chk("active", 128'(bullet_active_flat), 128'(e.act));
        chk("full",   128'(pool_full), 128'(e.full));
        chk("x",      128'(bullet_x_flat), 128'(e.xf));
        chk("y",      128'(bullet_y_flat), 128'(e.yf));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < RC; r++) begin pend[r] = 0; px[r] = 0; py[r] = 0; end
    model_reset();
    cyc = 0;
    last_grant_cycle = 0;

    repeat (3) @(posedge clk25);
    #1 check_cleared("reset");
    release_reset();

    // Single shot from requester 0, then let it fly for several ticks.
    px[0] = 100; py[0] = 400; pend[0] = 1;
    cycle('0);
    repeat (20) cycle('0);

    // Clean pool, then both requesters held continuously to fill it.
    pulse_reset();
    px[0] = 50;  py[0] = 300;
    px[1] = 500; py[1] = 200;
    for (int i = 0; i < 14; i++) begin
      pend[0] = 1; pend[1] = 1;
      cycle('0);
    end
    // Free slot 3 while both are still pending.
    pend[0] = 1; pend[1] = 1;
    cycle(8'b0000_1000);
    for (int i = 0; i < 4; i++) begin
      pend[0] = 1; pend[1] = 1;
      cycle('0);
    end
    pend[0] = 0; pend[1] = 0;

    // Top exit: clear everything, spawn at y=6 and watch it leave.
    cycle('1);
    px[0] = 321; py[0] = 6; pend[0] = 1;
    repeat (12) cycle('0);

    // Held single requester: back-to-back grants (spaced by cooldown if built).
    for (int i = 0; i < 30; i++) begin
      pend[0] = 1; px[0] = 10 + i; py[0] = 470;
      cycle((i % 3 == 0) ? 8'hff : 8'h00);
    end
    pend[0] = 0;

    // Reset while requests are pending; they are re-arbitrated from pointer 0.
    pend[0] = 1; pend[1] = 1; px[0] = 7; py[0] = 9; px[1] = 8; py[1] = 11;
    cycle('0);
    pend[0] = 1; pend[1] = 1;
    pulse_reset();
    repeat (5) cycle('0);

    // Randomised traffic with hits of varying density.
    for (int i = 0; i < 1500; i++) rand_cycle(15);
    for (int i = 0; i < 500; i++)  rand_cycle(3);
    for (int i = 0; i < 300; i++)  rand_cycle(60);

    @(negedge clk25);
    @(negedge clk25);
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
